// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int unsigned MdWidth = 32;

  // Operation codes presented on md_op; 3'b111 is undefined and ignored.
  typedef enum logic [2:0] {
    OpNop   = 3'b000,
    OpMultu = 3'b001,
    OpMult  = 3'b010,
    OpDivu  = 3'b011,
    OpDiv   = 3'b100,
    OpMthi  = 3'b101,
    OpMtlo  = 3'b110
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } md_state_e;

  // True for the op codes that launch the iterative engine.
  function automatic logic op_is_engine(logic [2:0] op);
    return (op == OpMultu) || (op == OpMult) || (op == OpDivu) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// One 2*WIDTH shift register and one WIDTH+1 adder serve both shift-add multiply
// and restoring divide; sign handling wraps the unsigned engine.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MdWidth,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_x,
  input  logic [WIDTH-1:0] md_y,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

  md_state_e          state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opa_q;     // |x|: multiplicand, or dividend magnitude for div-by-zero
  logic [WIDTH-1:0]   opb_q;     // |y|: divisor (multiplier lives in acc_q)
  logic               is_div_q;
  logic               neg_a_q;   // x was negative under a signed op
  logic               neg_b_q;   // y was negative under a signed op
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   abs_x, abs_y;
  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic               add_cin;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign abs_x = md_x[WIDTH-1] ? -md_x : md_x;
  assign abs_y = md_y[WIDTH-1] ? -md_y : md_y;

  // Shared adder: add multiplicand into upper half, or trial-subtract divisor from
  // the shifted remainder (WIDTH+1 bits so the shifted-out bit takes part).
  always_comb begin
    if (is_div_q) begin
      add_a   = acc_q[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, opa_q};
      add_cin = 1'b0;
    end
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
  end

  // One engine iteration: right shift with carry for mult, left shift plus
  // restore-or-keep for div (add_sum[WIDTH] set means the trial went negative).
  always_comb begin
    if (is_div_q) begin
      if (add_sum[WIDTH]) begin
        acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (acc_q[0]) begin
        acc_step = {add_sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  // Sign correction and divide-by-zero override applied on the FIX cycle.
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      if (opb_q == '0) begin
        res_lo = '1;
        res_hi = neg_a_q ? -opa_q : opa_q;
      end else begin
        res_lo = (neg_a_q ^ neg_b_q) ? -quo : quo;
        res_hi = neg_a_q ? -rem : rem;
      end
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Sequencer FSM plus HI/LO and done pulse; flush aborts from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (md_flush) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (md_start) begin
              if (op_is_engine(md_op)) begin
                state_q <= StRun;
                cnt_q   <= '0;
              end
              case (md_op)
                OpMultu: begin
                  opa_q    <= md_x;
                  opb_q    <= md_y;
                  acc_q    <= {{WIDTH{1'b0}}, md_y};
                  is_div_q <= 1'b0;
                  neg_a_q  <= 1'b0;
                  neg_b_q  <= 1'b0;
                end
                OpMult: begin
                  opa_q    <= abs_x;
                  opb_q    <= abs_y;
                  acc_q    <= {{WIDTH{1'b0}}, abs_y};
                  is_div_q <= 1'b0;
                  neg_a_q  <= md_x[WIDTH-1];
                  neg_b_q  <= md_y[WIDTH-1];
                end
                OpDivu: begin
                  opa_q    <= md_x;
                  opb_q    <= md_y;
                  acc_q    <= {{WIDTH{1'b0}}, md_x};
                  is_div_q <= 1'b1;
                  neg_a_q  <= 1'b0;
                  neg_b_q  <= 1'b0;
                end
                OpDiv: begin
                  opa_q    <= abs_x;
                  opb_q    <= abs_y;
                  acc_q    <= {{WIDTH{1'b0}}, abs_x};
                  is_div_q <= 1'b1;
                  neg_a_q  <= md_x[WIDTH-1];
                  neg_b_q  <= md_y[WIDTH-1];
                end
                OpMthi:  hi_q <= md_x;
                OpMtlo:  lo_q <= md_x;
                default: ;
              endcase
            end
          end
          StRun: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign md_busy = (state_q != StIdle);
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a cycle-level reference (operation countdown plus
// arithmetic result) is checked on every falling edge, and literal expectations
// pin the reference at each step.
module tb_muldiv_seq;

  localparam int W   = 32;
  localparam int LAT = 33;

  localparam logic [2:0] NOP = 3'b000, MULTU = 3'b001, MULT = 3'b010, DIVU = 3'b011,
                         DIV = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

  logic         clk, rst, md_start, md_flush;
  logic [2:0]   md_op;
  logic [W-1:0] md_x, md_y;
  logic         md_busy, md_done;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int          m_left;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_op    (md_op),
    .md_x     (md_x),
    .md_y     (md_y),
    .md_flush (md_flush),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (op)
      MULTU: p = {32'h0, x} * {32'h0, y};
      MULT:  p = sx * sy;
      DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      DIV: begin
        if (y == 0) begin
          p = {x, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Reference: an engine op keeps the unit busy for LAT cycles, then commits.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (md_flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (md_start && !md_flush) begin
        case (md_op)
          MULTU, MULT, DIVU, DIV: begin
            m_left <= LAT;
            m_pend <= ref_res(md_op, md_x, md_y);
          end
          MTHI:    m_hi <= md_x;
          MTLO:    m_lo <= md_x;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    check("cyc busy", {31'h0, md_busy}, {31'h0, (m_left != 0)});
    check("cyc done", {31'h0, md_done}, {31'h0, m_done});
    check("cyc hi", hi, m_hi);
    check("cyc lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    md_start = 1'b1;
    md_op    = op;
    md_x     = x;
    md_y     = y;
  endtask

  // Release start after one edge and wait (bounded) for the done pulse.
  task automatic wait_done(input string name, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      md_start = 1'b0;
      if (md_busy) nbusy++;
      if (md_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " done seen"}, {31'h0, seen}, 32'h1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int nb;
    issue(op, x, y);
    wait_done(name, nb);
    check({name, " busy cycles"}, nb, LAT);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int phase;
    bit seen;
    rst = 1'b1; md_start = 1'b0; md_flush = 1'b0; md_op = NOP; md_x = '0; md_y = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'h0, md_busy}, 32'h0);
    check("reset done", {31'h0, md_done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("divu by 0", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div -5 by 0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // MTHI in idle: immediate write, never busy.
    issue(MTHI, 32'h1234, 32'h0);
    @(negedge clk);
    md_start = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi busy", {31'h0, md_busy}, 32'h0);
    check("mthi lo kept", lo, 32'd14);

    // MTLO offered while busy is dropped.
    issue(DIVU, 32'd9, 32'd4);
    @(negedge clk);
    md_start = 1'b0;
    repeat (4) @(negedge clk);
    issue(MTLO, 32'hDEAD_BEEF, 32'h0);
    repeat (3) @(negedge clk);
    check("mtlo busy lo", lo, 32'd14);
    md_start = 1'b0;
    wait_done("divu 9/4", nb);
    check("divu 9/4 hi", hi, 32'd1);
    check("divu 9/4 lo", lo, 32'd2);

    // Flush at cycle 10: no result, no done.
    issue(DIVU, 32'd50, 32'd3);
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    check("flush busy", {31'h0, md_busy}, 32'h0);
    check("flush done", {31'h0, md_done}, 32'h0);
    check("flush hi", hi, 32'd1);
    check("flush lo", lo, 32'd2);
    repeat (40) @(negedge clk);

    // Flush and start together in idle: request dropped.
    issue(MTHI, 32'h5555, 32'h0);
    md_flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    md_flush = 1'b0;
    check("flush+start hi", hi, 32'd1);

    // Flush on the fix cycle suppresses the write.
    issue(MULTU, 32'd3, 32'd5);
    @(negedge clk);
    md_start = 1'b0;
    repeat (32) @(negedge clk);
    check("fix cycle busy", {31'h0, md_busy}, 32'h1);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    check("fix flush done", {31'h0, md_done}, 32'h0);
    check("fix flush lo", lo, 32'd2);
    check("fix flush hi", hi, 32'd1);

    // Reset mid-operation clears HI/LO.
    issue(DIVU, 32'd77, 32'd5);
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", {31'h0, md_busy}, 32'h0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    @(negedge clk);

    // Back-to-back: second request held until busy drops.
    issue(MULTU, 32'd3, 32'd5);
    nb = 0;
    phase = 0;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 0) begin
        md_op = DIVU;
        md_x  = 32'd9;
        md_y  = 32'd4;
      end
      if (md_busy) nb++;
      if (phase == 1) begin
        md_start = 1'b0;
        phase = 2;
      end
      if (phase == 0 && !md_busy) begin
        check("b2b multu lo", lo, 32'd15);
        check("b2b multu hi", hi, 32'd0);
        phase = 1;
      end else if (phase == 2 && md_done) begin
        seen = 1'b1;
        break;
      end
    end
    md_start = 1'b0;
    check("b2b done seen", {31'h0, seen}, 32'h1);
    check("b2b busy cycles", nb, 2 * LAT);
    check("b2b divu lo", lo, 32'd2);
    check("b2b divu hi", hi, 32'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
